uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
UART transmit controller that sequences one serial frame (start, data, optional parity, stop) on the `tx` line. It is paced by the oversampling tick from the baud `timer` block, whose `done` output connects to `s_tick`. It sits between the host-side byte interface and the pin, and it owns all frame timing; the `timer` only supplies the tick rate.

Parameters:
- DBIT, 8, number of data bits per frame (5..9), sent LSB first.
- OVS, 16, s_ticks per start, data or parity bit (oversampling factor, ≥2).
- SB_TICK, 16, s_ticks for the stop period (16 = 1, 24 = 1.5, 32 = 2 stop bits at OVS=16).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- s_tick, input, 1: one-clk-wide baud tick from `timer` `done`.
- tx_start, input, 1: request to send `din`; sampled only in IDLE.
- din, input, DBIT: data word; latched on an accepted `tx_start`.
- tx, output, 1: serial line, registered, idle high.
- busy, output, 1: high while a frame is in progress (state ≠ IDLE).
- tx_done_tick, output, 1: single-clk pulse when the stop period completes.

Behaviour:
- Reset values:
  - state = IDLE; tx = 1; busy = 0; tx_done_tick = 0.
  - Tick counter, bit counter and shift register all cleared.
- Internal state:
  - Tick counter s_cnt, width clog2(max(OVS, SB_TICK)).
  - Bit counter n_cnt, width clog2(DBIT).
  - Shift register b_reg, width DBIT.
- `tx` is a register loaded from the next-state line value, so `tx` always reflects the current state with no combinational glitches.
- IDLE:
  - tx = 1.
  - `tx_start` = 1 at a clk edge → b_reg ← din, s_cnt ← 0, go to START.
  - `tx` goes low and `busy` goes high on that same edge, so both are visible the next cycle.
  - `s_tick` is ignored in IDLE.
- START (tx = 0):
  - On `s_tick` with s_cnt == OVS-1 → s_cnt ← 0, n_cnt ← 0, go to DATA.
  - Otherwise, on `s_tick`, s_cnt increments.
- DATA (tx = b_reg[0]):
  - On `s_tick` with s_cnt == OVS-1 → s_cnt ← 0, b_reg shifts right.
  - If n_cnt == DBIT-1, go to PARITY (feature enabled) or STOP; else n_cnt increments.
- STOP (tx = 1):
  - On `s_tick` with s_cnt == SB_TICK-1 → go to IDLE.
  - On that edge, `tx_done_tick` = 1 for exactly one clk and `busy` falls.
- No tick-count drift: counters advance only on `s_tick`; clk cycles without `s_tick` hold all state.
- Frame duration = (1 + DBIT [+1 parity]) × OVS + SB_TICK s_ticks.
- `tx_start` while busy is ignored; no queuing. `din` changes after acceptance have no effect.
- `tx_start` high on the same edge `tx_done_tick` fires is not accepted. It is accepted on the following edge if still high, giving a back-to-back frame with exactly one idle clk.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously) and the frame is abandoned. No `tx_done_tick` is produced.
- The controller does not drive the `timer` enable; the `timer` free-runs. The first START bit may therefore be up to one tick period short, which is accepted (receiver resynchronises on the falling edge).

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Adds input port `parity_odd` (1 bit), sampled with `din` on acceptance.
  - Adds a PARITY state between DATA and STOP, lasting OVS s_ticks.
  - tx = (^latched_din) ^ parity_odd_latched: even parity when 0, odd when 1.
- Undefined:
  - No `parity_odd` port and no PARITY state.
  - DATA goes directly to STOP.

Test Plan:
1. Reset, with `s_tick` every 4 clk → tx = 1, busy = 0, tx_done_tick = 0. The line stays high for 200 clk with no `tx_start`.
2. DBIT=8, OVS=16, SB_TICK=16, `s_tick` every 4 clk; pulse `tx_start` with din = 0xA5:
   - tx sequence, each level 16 ticks: 0,1,0,1,0,0,1,0,1,1.
   - tx_done_tick pulses once, 160 ticks after start; busy is high throughout.
3. Assert `tx_start` with din = 0xFF mid-frame of a 0x00 frame → the line carries only the 0x00 frame, and exactly one tx_done_tick occurs.
4. Hold `tx_start` high with din = 0x3C continuously → back-to-back frames, each 160 ticks, separated by one idle clk. tx_done_tick pulses once per frame.
5. Assert reset during the DATA bit 3 of 0x55 → tx = 1 immediately and busy = 0. The next `tx_start` with 0x81 produces a clean full frame.
6. With UART_TX_PARITY_EN defined, din = 0x07:
   - parity_odd = 0 → parity bit 1.
   - parity_odd = 1 → parity bit 0.
   - Frame length is 176 ticks.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit frame sequencer.
//
// Sends one frame per accepted request: a start bit, DBIT data bits (LSB
// first), an optional parity bit, then the stop period. Timing is paced by
// s_tick, the oversampling tick from the free-running baud timer. OVS ticks
// make up each start, data or parity bit, and SB_TICK ticks make up the stop
// period. Clock cycles without s_tick hold all state.
//
// Optional feature: define UART_TX_PARITY_EN to add the parity_odd input
// and a PARITY state between DATA and STOP (0 = even, 1 = odd).
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   s_tick       one-clk baud oversampling tick
//   tx_start     send request, sampled only while idle
//   din          data word, latched when tx_start is accepted
//   parity_odd   parity sense, latched with din (UART_TX_PARITY_EN only)
//   tx           registered serial line, idle high
//   busy         high while a frame is in progress
//   tx_done_tick one-clk pulse when the stop period completes
module uart_tx_ctrl #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
`ifdef UART_TX_PARITY_EN
  input  logic            parity_odd,
`endif
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int CMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] OVS_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] SB_LAST  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_cnt_d = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          // The parity bit is fixed at acceptance so later din changes
          // cannot affect it.
          par_d   = (^din) ^ parity_odd;
`endif
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_cnt_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == OVS_LAST) begin
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SB_LAST) begin
            s_cnt_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The line level is derived from the next state (and the next shift
    // value), so the registered tx changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign busy         = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int DBIT    = 8;
  localparam int OVS     = 16;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int FLEN = (1 + DBIT + NPAR) * OVS + SB_TICK;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_tick;
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            parity_odd;
  logic            tx, busy, tx_done_tick;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_ctrl #(.DBIT(DBIT), .OVS(OVS), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick)
  );

  initial forever #5 clk = ~clk;

  // free-running baud tick, one clk in every four
  initial begin
    int div;
    div = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      s_tick = (div == 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level reference model ----------------
  // A frame is a list of bit levels, each held OVS ticks, followed by the
  // stop level for SB_TICK ticks; the model only counts ticks since acceptance.
  logic [11:0] m_fr = '0, n_fr;
  int          m_nb = 0, n_nb;
  int          m_t = 0, n_t;
  logic        m_busy = 1'b0, n_busy;
  logic        m_tx = 1'b1, n_tx;
  logic        m_done = 1'b0, n_done;

  function automatic logic level(input logic [11:0] fr, input int nb, input int t);
    if (t < nb * OVS) return fr[t / OVS];
    return 1'b1;
  endfunction

  always_comb begin
    n_fr   = m_fr;
    n_nb   = m_nb;
    n_t    = m_t;
    n_busy = m_busy;
    n_done = 1'b0;
    if (!m_busy) begin
      if (tx_start) begin
        n_fr = '0;
        for (int i = 0; i < DBIT; i++) n_fr[i + 1] = din[i];
        n_nb = 1 + DBIT;
`ifdef UART_TX_PARITY_EN
        n_fr[DBIT + 1] = (^din) ^ parity_odd;
        n_nb = 2 + DBIT;
`endif
        n_t    = 0;
        n_busy = 1'b1;
      end
    end else if (s_tick) begin
      n_t = m_t + 1;
      if (n_t == n_nb * OVS + SB_TICK) begin
        n_busy = 1'b0;
        n_done = 1'b1;
      end
    end
    n_tx = n_busy ? level(n_fr, n_nb, n_t) : 1'b1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_tx   <= 1'b1;
      m_done <= 1'b0;
      m_t    <= 0;
    end else begin
      m_fr   <= n_fr;
      m_nb   <= n_nb;
      m_t    <= n_t;
      m_busy <= n_busy;
      m_tx   <= n_tx;
      m_done <= n_done;
    end
  end

  always @(negedge clk) begin
    chk("tx_cycle", int'(tx), int'(m_tx));
    chk("busy_cycle", int'(busy), int'(m_busy));
    chk("done_cycle", int'(tx_done_tick), int'(m_done));
  end

  // ---------------- line monitor (captures DUT behaviour) ----------------
  logic cap [0:11];
  int   mon_t = 0, done_cnt = 0, last_len = 0, idle_run = 0, last_gap = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_t    <= 0;
      idle_run <= 0;
    end else begin
      if (busy && s_tick) begin
        if (mon_t % OVS == OVS / 2) cap[mon_t / OVS] <= tx;
        mon_t <= mon_t + 1;
      end else if (!busy) begin
        mon_t <= 0;
      end
      if (tx_done_tick) begin
        done_cnt <= done_cnt + 1;
        last_len <= mon_t;
      end
      if (!busy) idle_run <= idle_run + 1;
      else begin
        if (idle_run != 0) last_gap <= idle_run;
        idle_run <= 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DBIT-1:0] d, input logic po);
    @(negedge clk);
    din = d;
    parity_odd = po;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c0, k;
    c0 = done_cnt;
    k = 0;
    while (done_cnt == c0 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, int'(done_cnt != c0), 1);
  endtask

  task automatic wait_tick(input int target, input string tag);
    int k;
    k = 0;
    while (mon_t < target && k < 1500) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reached"}, int'(mon_t >= target), 1);
  endtask

  // exp bit i is the level of frame bit i (0 = start bit)
  task automatic check_frame(input logic [11:0] exp, input int nbits, input int len,
                             input string tag);
    for (int i = 0; i < nbits; i++)
      chk($sformatf("%s_bit%0d", tag, i), int'(cap[i]), int'(exp[i]));
    chk({tag, "_len"}, last_len, len);
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    tx_start = 1'b0;
    din = '0;
    parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(tx_done_tick), 0);
    reset = 1'b0;

    // 1: idle line stays high
    repeat (200) @(negedge clk);
    chk("idle_tx", int'(tx), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_no_done", done_cnt, 0);

    // 2: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0);
    wait_done("a5");
    check_frame(12'b00_1101001010, 10 - NPAR, FLEN, "a5");

    // 3: request during a frame is ignored
    d0 = done_cnt;
    send(8'h00, 1'b0);
    wait_tick(40, "midframe");
    @(negedge clk);
    din = 8'hFF;
    tx_start = 1'b1;
    repeat (8) @(negedge clk);
    tx_start = 1'b0;
    wait_done("zero");
    check_frame(12'b00_1000000000, 10 - NPAR, FLEN, "zero");
    repeat (100) @(negedge clk);
    chk("zero_one_done", done_cnt - d0, 1);

    // 4: held request -> back-to-back frames with one idle clk between
    @(negedge clk);
    din = 8'h3C;
    tx_start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done($sformatf("b2b%0d", f));
      check_frame(12'b00_1001111000, 10 - NPAR, FLEN, $sformatf("b2b%0d", f));
    end
    tx_start = 1'b0;
    chk("b2b_gap", last_gap, 1);
    wait_done("b2b_last");

    // 5: reset during data bit 3 of 0x55
    d0 = done_cnt;
    send(8'h55, 1'b0);
    wait_tick(70, "rst_point");
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_tx_now", int'(tx), 1);
    chk("rst_busy_now", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    send(8'h81, 1'b0);
    wait_done("x81");
    check_frame(12'b00_1100000010, 10 - NPAR, FLEN, "x81");

`ifdef UART_TX_PARITY_EN
    // 6: parity on 0x07 (three ones)
    send(8'h07, 1'b0);
    wait_done("par_even");
    check_frame(12'b0_11000001110, 12, 176, "par_even");
    send(8'h07, 1'b1);
    wait_done("par_odd");
    check_frame(12'b0_10000001110, 12, 176, "par_odd");
`endif

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
